// File: rtl/input_block_buffer.sv
// input_block_buffer: router input port. It is a circular FIFO that holds
// incoming flits. When a header reaches the head of the FIFO, the block
// latches the done/x/y fields from it and raises a routing request. After the
// switch allocator grants the request, the block forwards one packet of
// PACKET_FLITS flits and returns a one-cycle credit for each flit it pops.
// Optional build macro: INPUT_BUFFER_ERR_EN adds the sticky error_dout
// overflow flag. In the default build that port does not exist.

`ifndef X_POS
`define X_POS 0
`endif

`ifndef ADDR_FIELD
`define ADDR_FIELD 4
`endif

module input_block_buffer #(
    parameter int PORT_DIR     = `X_POS,
    parameter int FLIT_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 5,
    parameter int PACKET_FLITS = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FLIT_WIDTH-1:0]  channel_din,
    input  logic                   write_strobe_din,
    input  logic                   grant_din,
    output logic [FLIT_WIDTH-1:0]  channel_dout,
    output logic                   valid_dout,
    output logic                   credit_out_dout,
    output logic                   header_valid_dout,
    output logic                   done_field_dout,
    output logic [`ADDR_FIELD-1:0] x_field_dout,
    output logic [`ADDR_FIELD-1:0] y_field_dout
`ifdef INPUT_BUFFER_ERR_EN
    ,
    output logic                   error_dout
`endif
);

    localparam int AW    = `ADDR_FIELD;
    localparam int PTR_W = $clog2(BUFFER_DEPTH);
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam int FC_W  = $clog2(PACKET_FLITS + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUFFER_DEPTH);
    localparam logic [FC_W-1:0]  LAST_FLIT = FC_W'(PACKET_FLITS - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQUEST  = 2'd1;
    localparam logic [1:0] TRANSFER = 2'd2;

    // Reject configurations the FIFO and header decode cannot support.
    // Direction codes are non-negative.
    if (BUFFER_DEPTH < 2 || BUFFER_DEPTH > 16 ||
        PACKET_FLITS < 1 || PACKET_FLITS > BUFFER_DEPTH ||
        FLIT_WIDTH < 2 * AW + 1 || PORT_DIR < 0) begin : g_bad_params
        $error("input_block_buffer: illegal parameter combination");
    end

    logic [FLIT_WIDTH-1:0] mem_q [BUFFER_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [FC_W-1:0]  flit_cnt_q, flit_cnt_d;
    logic             hdr_latched_q, hdr_latched_d;
    logic             done_q, done_d;
    logic [AW-1:0]    x_q, x_d;
    logic [AW-1:0]    y_q, y_d;
    logic             credit_q, credit_d;

    logic empty;
    logic full;
    logic pop;
    logic push;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // A flit leaves only while a granted packet is in flight. An incoming
    // flit fits if a slot is free or if the head leaves on the same edge.
    // A write to a full FIFO with no pop is dropped silently.
    assign pop  = (state_q == TRANSFER) && !empty;
    assign push = write_strobe_din && (!full || pop);

    // Store accepted flits at the write pointer.
    // NOTE: the storage array has no reset. The pointers and the count
    // decide which entries are live, so an entry is always written before it
    // is read, and clearing the array would add reset fan-out with no benefit.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= channel_din;
        end
    end

    // The head entry drives the output combinationally. After reset its
    // contents are meaningless until the first write.
    assign channel_dout = mem_q[rd_ptr_q];

    // Pointer and occupancy next state. The pointers wrap explicitly, so the
    // FIFO works for depths that are not a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Packet FSM. In IDLE the first edge latches the head flit's header
    // fields and the next edge raises the request. This keeps the fields
    // stable for a full cycle before the allocator sees them.
    always_comb begin
        // NOTE: every signal assigned in this block gets its hold value
        // first. Each path through the case therefore assigns it, and no
        // latch is inferred.
        state_d       = state_q;
        flit_cnt_d    = flit_cnt_q;
        hdr_latched_d = hdr_latched_q;
        done_d        = done_q;
        x_d           = x_q;
        y_d           = y_q;
        case (state_q)
            IDLE: begin
                if (hdr_latched_q) begin
                    state_d       = REQUEST;
                    hdr_latched_d = 1'b0;
                end else if (!empty) begin
                    hdr_latched_d = 1'b1;
                    done_d        = channel_dout[FLIT_WIDTH-1];
                    x_d           = channel_dout[FLIT_WIDTH-2 -: AW];
                    y_d           = channel_dout[FLIT_WIDTH-2-AW -: AW];
                end
            end
            REQUEST: begin
                if (grant_din) begin
                    state_d    = TRANSFER;
                    flit_cnt_d = '0;
                end
            end
            TRANSFER: begin
                if (pop) begin
                    if (flit_cnt_q == LAST_FLIT) begin
                        state_d    = IDLE;
                        flit_cnt_d = '0;
                    end else begin
                        flit_cnt_d = flit_cnt_q + FC_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Each pop returns one credit upstream on the following cycle.
    assign credit_d = pop;

    // State registers. Reset is asynchronous, so an abort in the middle of a
    // packet discards the buffered flits and any credit still pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            flit_cnt_q    <= '0;
            hdr_latched_q <= 1'b0;
            done_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            credit_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here update
            // from the values that were present before the edge.
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            flit_cnt_q    <= flit_cnt_d;
            hdr_latched_q <= hdr_latched_d;
            done_q        <= done_d;
            x_q           <= x_d;
            y_q           <= y_d;
            credit_q      <= credit_d;
        end
    end

    assign valid_dout        = pop;
    assign header_valid_dout = (state_q == REQUEST);
    assign credit_out_dout   = credit_q;
    assign done_field_dout   = done_q;
    assign x_field_dout      = x_q;
    assign y_field_dout      = y_q;

`ifdef INPUT_BUFFER_ERR_EN
    logic error_q, error_d;
    logic overflow;

    assign overflow = write_strobe_din && full && !pop;
    assign error_d  = error_q | overflow;

    // Sticky overflow flag. Only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_dout = error_q;
`endif

endmodule

// File: tb/tb_input_block_buffer.sv
// tb_input_block_buffer: scoreboard bench for input_block_buffer.
// It runs two instances with BUFFER_DEPTH 5 side by side: one with
// PACKET_FLITS 5 and one with PACKET_FLITS 1. A cycle-level reference model
// built on queues predicts each output. Flits the model accepts go into a
// scoreboard queue, and a negedge monitor pops that queue whenever the DUT
// asserts valid_dout.
// Optional build macro: INPUT_BUFFER_ERR_EN enables the error_dout checks.
`timescale 1ns/1ps

`ifndef ADDR_FIELD
`define ADDR_FIELD 4
`endif

module tb_input_block_buffer;

    localparam int FW    = 32;
    localparam int AF    = `ADDR_FIELD;
    localparam int DEPTH = 5;
    localparam int PF [2] = '{5, 1};

    localparam int M_IDLE    = 0;
    localparam int M_LATCHED = 1;
    localparam int M_REQ     = 2;
    localparam int M_XFER    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [FW-1:0] din [2];
    logic          wr  [2];
    logic          gnt [2];
    logic [FW-1:0] dout [2];
    logic          vld  [2];
    logic          crd  [2];
    logic          hv   [2];
    logic          done [2];
    logic [AF-1:0] xf   [2];
    logic [AF-1:0] yf   [2];
`ifdef INPUT_BUFFER_ERR_EN
    logic          err  [2];
    bit            m_err [2] = '{1'b0, 1'b0};
`endif

    always #5 clk = ~clk;

    input_block_buffer #(.FLIT_WIDTH(FW), .BUFFER_DEPTH(DEPTH), .PACKET_FLITS(5)) u_dut0 (
        .clk(clk), .reset(reset), .channel_din(din[0]), .write_strobe_din(wr[0]),
        .grant_din(gnt[0]), .channel_dout(dout[0]), .valid_dout(vld[0]),
        .credit_out_dout(crd[0]), .header_valid_dout(hv[0]), .done_field_dout(done[0]),
        .x_field_dout(xf[0]), .y_field_dout(yf[0])
`ifdef INPUT_BUFFER_ERR_EN
        , .error_dout(err[0])
`endif
    );

    input_block_buffer #(.FLIT_WIDTH(FW), .BUFFER_DEPTH(DEPTH), .PACKET_FLITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .channel_din(din[1]), .write_strobe_din(wr[1]),
        .grant_din(gnt[1]), .channel_dout(dout[1]), .valid_dout(vld[1]),
        .credit_out_dout(crd[1]), .header_valid_dout(hv[1]), .done_field_dout(done[1]),
        .x_field_dout(xf[1]), .y_field_dout(yf[1])
`ifdef INPUT_BUFFER_ERR_EN
        , .error_dout(err[1])
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_pop  [2] = '{0, 0};
    int n_cred [2] = '{0, 0};

    task automatic check(string name, int d, logic [FW-1:0] act, logic [FW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", name, d, $time, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [FW-1:0] mq [2][$];   // flits currently held in the buffer
    logic [FW-1:0] sb [2][$];   // expected delivery order
    int            m_phase  [2] = '{M_IDLE, M_IDLE};
    int            m_sent   [2] = '{0, 0};
    bit            m_credit [2] = '{1'b0, 1'b0};
    bit            m_acc    [2] = '{1'b0, 1'b0};
    bit            m_done   [2] = '{1'b0, 1'b0};
    logic [AF-1:0] m_x      [2] = '{'0, '0};
    logic [AF-1:0] m_y      [2] = '{'0, '0};

    function automatic bit m_valid(int d);
        return (m_phase[d] == M_XFER) && (mq[d].size() > 0);
    endfunction

    function automatic bit busy(int d);
        return (mq[d].size() > 0) || (m_phase[d] != M_IDLE) || m_credit[d];
    endfunction

    task automatic model_step(int d);
        bit pop = m_valid(d);
        int occ = mq[d].size();
        m_acc[d] = wr[d] && (occ < DEPTH || pop);
`ifdef INPUT_BUFFER_ERR_EN
        if (wr[d] && occ == DEPTH && !pop) m_err[d] = 1'b1;
`endif
        case (m_phase[d])
            M_IDLE: if (occ > 0) begin
                m_done[d]  = mq[d][0][FW-1];
                m_x[d]     = mq[d][0][FW-2 -: AF];
                m_y[d]     = mq[d][0][FW-2-AF -: AF];
                m_phase[d] = M_LATCHED;
            end
            M_LATCHED: m_phase[d] = M_REQ;
            M_REQ: if (gnt[d]) begin
                m_phase[d] = M_XFER;
                m_sent[d]  = 0;
            end
            default: if (pop) begin
                m_sent[d]++;
                if (m_sent[d] == PF[d]) m_phase[d] = M_IDLE;
            end
        endcase
        m_credit[d] = pop;
        if (pop) void'(mq[d].pop_front());
        if (m_acc[d]) begin
            mq[d].push_back(din[d]);
            sb[d].push_back(din[d]);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                mq[d].delete();
                sb[d].delete();
                m_phase[d]  = M_IDLE;
                m_sent[d]   = 0;
                m_credit[d] = 1'b0;
                m_acc[d]    = 1'b0;
                m_done[d]   = 1'b0;
                m_x[d]      = '0;
                m_y[d]      = '0;
`ifdef INPUT_BUFFER_ERR_EN
                m_err[d]    = 1'b0;
`endif
            end else begin
                model_step(d);
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (vld[d] === 1'b1) begin
                n_pop[d]++;
                if (sb[d].size() == 0) check("unexpected_flit", d, dout[d], 'x);
                else check("flit_data", d, dout[d], sb[d].pop_front());
            end
            if (crd[d] === 1'b1) n_cred[d]++;
            check("valid_dout", d, FW'(vld[d]), FW'(m_valid(d)));
            check("credit_out", d, FW'(crd[d]), FW'(m_credit[d]));
            check("header_valid", d, FW'(hv[d]), FW'(m_phase[d] == M_REQ));
            check("done_field", d, FW'(done[d]), FW'(m_done[d]));
            check("x_field", d, FW'(xf[d]), FW'(m_x[d]));
            check("y_field", d, FW'(yf[d]), FW'(m_y[d]));
`ifdef INPUT_BUFFER_ERR_EN
            check("error_dout", d, FW'(err[d]), FW'(m_err[d]));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] make_hdr(bit dn, logic [AF-1:0] x, logic [AF-1:0] y);
        logic [FW-1:0] f = FW'($urandom());
        f[FW-1]          = dn;
        f[FW-2 -: AF]    = x;
        f[FW-2-AF -: AF] = y;
        return f;
    endfunction

    function automatic logic [FW-1:0] gen_flit(int d, int k);
        if (k % PF[d] == 0)
            return make_hdr(1'($urandom_range(0, 1)), AF'($urandom()), AF'($urandom()));
        return FW'($urandom());
    endfunction

    task automatic write_packet(int d, logic [FW-1:0] hdr);
        for (int i = 0; i < PF[d]; i++) begin
            wr[d]  = 1'b1;
            din[d] = (i == 0) ? hdr : FW'($urandom());
            cyc();
        end
        wr[d] = 1'b0;
    endtask

    task automatic wait_hv(int d);
        int n = 0;
        while (hv[d] !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        check("header_valid_wait", d, FW'(hv[d]), FW'(1));
    endtask

    task automatic grant_pulse(int d);
        gnt[d] = 1'b1;
        cyc();
        gnt[d] = 1'b0;
    endtask

    task automatic drain(int d);
        int n = 0;
        while (busy(d) && n < 200) begin
            cyc();
            n++;
        end
        check("drain_quiet", d, FW'(hv[d] | vld[d] | crd[d]), '0);
    endtask

    task automatic check_fields(int d, bit dn, int x, int y);
        check("hdr_done", d, FW'(done[d]), FW'(dn));
        check("hdr_x", d, FW'(xf[d]), FW'(x));
        check("hdr_y", d, FW'(yf[d]), FW'(y));
    endtask

    // Random flit stream with random strobes and random grants. The writer
    // never overflows the buffer. With fill_first set, grants are withheld
    // until the buffer fills, so later writes land while full with a pop.
    task automatic stream(int d, int n, bit fill_first, bit dense);
        int k = 0;
        int guard = 0;
        int p0 = n_pop[d];
        int c0 = n_cred[d];
        bit was_full = !fill_first;
        logic [FW-1:0] f = gen_flit(d, 0);
        while ((k < n || busy(d)) && guard < 3000) begin
            if (mq[d].size() == DEPTH) was_full = 1'b1;
            gnt[d] = was_full ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k < n && !(mq[d].size() == DEPTH && !m_valid(d)) &&
                (dense || $urandom_range(0, 2) != 0)) begin
                wr[d]  = 1'b1;
                din[d] = f;
            end else begin
                wr[d] = 1'b0;
            end
            cyc();
            if (wr[d] && m_acc[d]) begin
                k++;
                f = gen_flit(d, k);
            end
            guard++;
        end
        wr[d]  = 1'b0;
        gnt[d] = 1'b0;
        check("stream_pops", d, FW'(n_pop[d] - p0), FW'(n));
        check("stream_credits", d, FW'(n_cred[d] - c0), FW'(n));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int p0, c0, n;
        for (int d = 0; d < 2; d++) begin
            wr[d] = 1'b0; gnt[d] = 1'b0; din[d] = '0;
        end
        #1 reset = 1'b1;
        repeat (3) cyc();
        for (int d = 0; d < 2; d++) begin
            check("reset_valid", d, FW'(vld[d]), '0);
            check("reset_credit", d, FW'(crd[d]), '0);
            check("reset_hv", d, FW'(hv[d]), '0);
            check_fields(d, 1'b0, 0, 0);
        end
        reset = 1'b0;
        cyc();

        // Basic packet: header done=1 x=2 y=1, then grant one cycle later.
        p0 = n_pop[0]; c0 = n_cred[0];
        write_packet(0, make_hdr(1'b1, AF'(2), AF'(1)));
        wait_hv(0);
        check_fields(0, 1'b1, 2, 1);
        cyc();
        grant_pulse(0);
        drain(0);
        check("pkt_pops", 0, FW'(n_pop[0] - p0), FW'(5));
        check("pkt_credits", 0, FW'(n_cred[0] - c0), FW'(5));

        // Grant withheld for 10 cycles while the request is up.
        p0 = n_pop[0]; c0 = n_cred[0];
        write_packet(0, make_hdr(1'b0, AF'(9), AF'(6)));
        wait_hv(0);
        repeat (10) begin
            cyc();
            check("hold_hv", 0, FW'(hv[0]), FW'(1));
            check_fields(0, 1'b0, 9, 6);
        end
        check("hold_no_pop", 0, FW'(n_pop[0] - p0), '0);
        check("hold_no_credit", 0, FW'(n_cred[0] - c0), '0);
        grant_pulse(0);
        drain(0);

        // Two packets back to back, including writes into a full buffer
        // that is popping on the same edge. Pointers wrap twice.
        stream(0, 10, 1'b1, 1'b1);

        // Reset after the third flit of a packet has been popped.
        write_packet(0, make_hdr(1'b1, AF'(3), AF'(4)));
        wait_hv(0);
        grant_pulse(0);
        p0 = n_pop[0] - 1;
        n = 0;
        while (n_pop[0] - p0 < 3 && n < 50) begin
            cyc();
            n++;
        end
        check("pops_before_reset", 0, FW'(n_pop[0] - p0), FW'(3));
        cyc();
        c0 = n_cred[0];
        reset = 1'b1;
        #1;
        check("async_valid", 0, FW'(vld[0]), '0);
        check("async_credit", 0, FW'(crd[0]), '0);
        check("async_hv", 0, FW'(hv[0]), '0);
        check_fields(0, 1'b0, 0, 0);
        repeat (3) cyc();
        reset = 1'b0;
        repeat (5) cyc();
        check("no_credit_after_reset", 0, FW'(n_cred[0] - c0), '0);
        p0 = n_pop[0]; c0 = n_cred[0];
        write_packet(0, make_hdr(1'b0, AF'(5), AF'(12)));
        wait_hv(0);
        check_fields(0, 1'b0, 5, 12);
        grant_pulse(0);
        drain(0);
        check("post_reset_pops", 0, FW'(n_pop[0] - p0), FW'(5));
        check("post_reset_credits", 0, FW'(n_cred[0] - c0), FW'(5));

        // Sixth flit into a full buffer with no grant: it must be dropped.
        p0 = n_pop[0];
        write_packet(0, make_hdr(1'b1, AF'(7), AF'(0)));
        wr[0] = 1'b1; din[0] = FW'($urandom());
        cyc();
        wr[0] = 1'b0;
        cyc();
`ifdef INPUT_BUFFER_ERR_EN
        check("overflow_error", 0, FW'(err[0]), FW'(1));
`endif
        wait_hv(0);
        grant_pulse(0);
        drain(0);
        check("overflow_pops", 0, FW'(n_pop[0] - p0), FW'(5));
`ifdef INPUT_BUFFER_ERR_EN
        check("error_sticky", 0, FW'(err[0]), FW'(1));
`endif

        // Random traffic on both instances.
        stream(0, 15, 1'b0, 1'b0);

        // Single-flit packets: the header is the whole packet.
        p0 = n_pop[1]; c0 = n_cred[1];
        write_packet(1, make_hdr(1'b1, AF'(1), AF'(3)));
        wait_hv(1);
        check_fields(1, 1'b1, 1, 3);
        grant_pulse(1);
        check("pf1_pop", 1, FW'(vld[1]), FW'(1));
        cyc();
        check("pf1_credit", 1, FW'(crd[1]), FW'(1));
        check("pf1_idle_valid", 1, FW'(vld[1]), '0);
        check("pf1_idle_hv", 1, FW'(hv[1]), '0);
        drain(1);
        check("pf1_pops", 1, FW'(n_pop[1] - p0), FW'(1));
        check("pf1_credits", 1, FW'(n_cred[1] - c0), FW'(1));
        stream(1, 6, 1'b0, 1'b0);

        // A final reset clears the sticky flag.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
`ifdef INPUT_BUFFER_ERR_EN
        check("error_cleared", 0, FW'(err[0]), '0);
`endif
        check("final_quiet", 0, FW'(vld[0] | hv[0] | crd[0]), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
